// File: rtl/p_cacheline_adaptor.sv
// Bridges 256-bit cache line requests to four-beat 64-bit bursts on the memory bus.
// Read beats are assembled into a line; write lines are streamed out one beat per accept.
module p_cacheline_adaptor #(
    parameter int s_offset = 5,
    parameter int s_line   = 256,
    parameter int s_beat   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [31:0]       pmem_address,
    input  logic [s_line-1:0] pmem_wdata,
    output logic [s_line-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic              bus_read,
    output logic              bus_write,
    output logic [31:0]       bus_address,
    output logic [s_beat-1:0] bus_wdata,
    input  logic [s_beat-1:0] bus_rdata,
    input  logic              bus_resp
);

    localparam int beats = s_line / s_beat;
    localparam int cnt_w = $clog2(beats);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t             state, next_state;
    logic [cnt_w-1:0]   cnt;
    logic [s_line-1:0]  line_buf;
    logic [s_line-1:0]  rdata_reg;
    logic [31:0]        addr_reg;
    logic               last_beat;

    assign last_beat = (cnt == cnt_w'(beats - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (pmem_read)       next_state = RD;
                else if (pmem_write) next_state = WR;
            end
            RD:      if (bus_resp && last_beat) next_state = DONE;
            WR:      if (bus_resp && last_beat) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Read wins over write when both arrive together; the write line is then not latched.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            line_buf  <= '0;
            rdata_reg <= '0;
            addr_reg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pmem_read || pmem_write)
                        addr_reg <= {pmem_address[31:s_offset], {s_offset{1'b0}}};
                    if (!pmem_read && pmem_write)
                        line_buf <= pmem_wdata;
                end
                RD: begin
                    if (bus_resp) begin
                        line_buf[s_beat*int'(cnt) +: s_beat] <= bus_rdata;
                        cnt <= last_beat ? '0 : cnt + 1'b1;
                        if (last_beat)
                            rdata_reg <= {bus_rdata, line_buf[s_line-s_beat-1:0]};
                    end
                end
                WR: begin
                    if (bus_resp)
                        cnt <= last_beat ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pmem_resp   = (state == DONE);
    assign bus_read    = (state == RD);
    assign bus_write   = (state == WR);
    assign bus_address = addr_reg;
    assign bus_wdata   = line_buf[s_beat*int'(cnt) +: s_beat];
    assign pmem_rdata  = rdata_reg;

endmodule
